// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/writeback and drives datapath enables and mux selects.
// Optional macro COND_EXEC_EN enables condition-field predication; when undefined every instruction executes.
module mc_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Cond,
    input  logic [1:0] ZC,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Fwrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALU_Control,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic       cond_ex;
    logic [3:0] cmd;

    assign cmd   = Funct[4:1];
    assign State = state;

    function automatic logic [2:0] alu_dec(input logic [3:0] c);
        case (c)
            4'b0100: alu_dec = 3'b000;
            4'b0010: alu_dec = 3'b001;
            4'b1010: alu_dec = 3'b001;
            4'b0000: alu_dec = 3'b010;
            4'b1100: alu_dec = 3'b011;
            4'b0001: alu_dec = 3'b100;
            4'b1101: alu_dec = 3'b111;
            default: alu_dec = 3'b101;
        endcase
    endfunction

`ifdef COND_EXEC_EN
    always_comb begin
        case (Cond)
            4'b0000: cond_ex = ZC[0];
            4'b0001: cond_ex = ~ZC[0];
            4'b0010: cond_ex = ZC[1];
            4'b0011: cond_ex = ~ZC[1];
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = &{1'b0, Cond, ZC};
    assign cond_ex     = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = FETCH;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        Fwrite      = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALU_Control = 3'b000;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_nxt = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
                state_nxt = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                MemWrite  = cond_ex;
            end
            EXECR, EXECI: begin
                ALUSrcB     = (state == EXECI) ? 2'b01 : 2'b00;
                ALU_Control = alu_dec(cmd);
                // Flags latch on the edge leaving EXEC, ahead of writeback.
                Fwrite      = Funct[0] & cond_ex;
                state_nxt   = ALUWB;
            end
            ALUWB: begin
                RegWrite = cond_ex & (cmd != 4'b1010);
            end
            BRANCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: state_nxt = FETCH;
        endcase
        // Writes are suppressed for the whole time reset is held.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Fwrite   = 1'b0;
        end
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rst input 1, with rst asserting at once regardless of clk.
REQ-002 clk  input  1  rising-edge clock for the state register.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  bit5 I (immediate), bits4:1 cmd, bit0 S; for memory, bit0 L (load).
REQ-006 Cond  input  4  condition field of the instruction.
REQ-007 ZC  input  2  registered ALU flags: bit1 C, bit0 Z.
REQ-008 PCWrite, IRWrite, RegWrite, MemWrite, Fwrite  output  1 each  write enables.
REQ-009 AdrSrc, ALUSrcA  output  1 each  mux selects.
REQ-010 ALUSrcB, ResultSrc  output  2 each  mux selects.
REQ-011 ALU_Control  output  3  ALU operation code.
REQ-012 State  output  4  current state, for debug.

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8 and BRANCH=9; codes 10-15 SHALL go to FETCH on the next edge.
REQ-014 FETCH SHALL assert IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU_Control=000 and ResultSrc=10, then go to DECODE.
REQ-015 DECODE SHALL set ALUSrcA=1, ALUSrcB=10, ALU_Control=000 and ResultSrc=10, with no write enable, then branch as follows:
- Op=01 -> MEMADR
- Op=00 with I=0 -> EXECR
- Op=00 with I=1 -> EXECI
- Op=10 -> BRANCH
- Op=11 -> FETCH
REQ-016 MEMADR SHALL set ALUSrcA=0, ALUSrcB=01 and ALU_Control=000, then go to MEMRD if L=1, else MEMWR.
REQ-017 MEMRD SHALL set ResultSrc=00 and AdrSrc=1, then go to MEMWB.
REQ-018 MEMWB SHALL set ResultSrc=01 and RegWrite=CondEx, then go to FETCH.
REQ-019 MEMWR SHALL set ResultSrc=00, AdrSrc=1 and MemWrite=CondEx, then go to FETCH.
REQ-020 EXECR SHALL set ALUSrcA=0 and ALUSrcB=00; EXECI SHALL set ALUSrcA=0 and ALUSrcB=01; both SHALL then go to ALUWB.
REQ-021 EXECR and EXECI SHALL set Fwrite=S&CondEx, so the ALU flags latch on the edge that leaves EXEC.
REQ-022 ALU_Control SHALL decode cmd in EXEC states; in every other state it SHALL be 000.
- 0100 ADD -> 000
- 0010 SUB -> 001
- 1010 CMP -> 001
- 0000 AND -> 010
- 1100 ORR -> 011
- 0001 EOR -> 100
- 1101 MOV -> 111
- others -> 101
REQ-023 ALUWB SHALL set ResultSrc=00, then go to FETCH.
REQ-024 In ALUWB, RegWrite SHALL be 1 only when CondEx=1 and cmd is not CMP (1010).
REQ-025 BRANCH SHALL set ALUSrcA=0, ALUSrcB=10, ALU_Control=000, ResultSrc=10 and PCWrite=CondEx, then go to FETCH.
REQ-026 CondEx SHALL be a combinational function of Cond and ZC:
- 0000 -> Z
- 0001 -> !Z
- 0010 -> C
- 0011 -> !C
- 1110 -> 1
- others -> 0
REQ-027 Any output not named for a state SHALL be 0 in that state.
REQ-028 Latency SHALL be:
- LDR: 5 cycles
- STR: 4 cycles
- data-processing: 4 cycles
- branch: 3 cycles
- undefined: 2 cycles

Reset
REQ-029 rst=1 SHALL force State=FETCH immediately.
REQ-030 While rst=1, PCWrite, IRWrite, RegWrite, MemWrite and Fwrite SHALL be 0.
REQ-031 After rst deasserts, the first rising clk edge SHALL complete FETCH.
REQ-032 Reset asserted mid-instruction SHALL abort that instruction with no further write.

Configuration
REQ-033 With COND_EXEC_EN defined, CondEx SHALL follow REQ-026.
REQ-034 With COND_EXEC_EN undefined, CondEx SHALL be constant 1 and Cond SHALL be ignored.

Verification
REQ-035 Reset: rst=1 during MEMRD -> State=0 at once, all enables 0; rst=0 -> State sequence 0,1,...
REQ-036 ADD with S=1: Op=00, Funct=001001, Cond=1110 -> states 0,1,6,8,0; ALU_Control=000 in state 6; Fwrite=1 in state 6; RegWrite=1 in state 8.
REQ-037 CMP: Funct=110101, Cond=1110 -> states 0,1,7,8; ALU_Control=001; Fwrite=1; RegWrite=0 in state 8.
REQ-038 LDR: Op=01, L=1 -> states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 in state 4.
REQ-039 Branch with Cond=0000 -> ZC=01 gives PCWrite=1 in state 9; ZC=00 gives PCWrite=0.
REQ-040 COND_EXEC_EN: Cond=0000 and ZC=00 -> PCWrite=1 in state 9 with the macro undefined, and 0 with it defined.
